// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB master port between NB_REQ requesters.
// Requesters are served round-robin. The FSM walks IDLE -> SETUP -> ACCESS and
// returns to IDLE on pready_i or when the watchdog expires. Completion status
// (read data, error flag, one-hot rvalid) is registered toward the owner.
module apb_master_arbiter #(
  parameter int NB_REQ         = 3,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT        = 256
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NB_REQ-1:0]                         req_i,
  input  logic [NB_REQ-1:0]                         we_i,
  input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]     addr_i,
  input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]     wdata_i,
  output logic [NB_REQ-1:0]                         gnt_o,
  output logic [NB_REQ-1:0]                         rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]                 rdata_o,
  output logic                                      err_o,
  output logic                                      psel_o,
  output logic                                      penable_o,
  output logic                                      pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]                 paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                 pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]                 prdata_i,
  input  logic                                      pready_i,
  input  logic                                      pslverr_i
);

  localparam int IDX_W = $clog2(NB_REQ);
  // The watchdog only has to reach TIMEOUT-1; a disabled watchdog keeps a 1-bit stub.
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : {WD_W{1'b0}};
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [NB_REQ-1:0] ONE_HOT0 = {{(NB_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [IDX_W-1:0]          r_rr_ptr;
  logic [IDX_W-1:0]          r_owner;
  logic                      r_pwrite;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic [WD_W-1:0]           r_wdog;
  logic [NB_REQ-1:0]         r_rvalid;
  logic [APB_DATA_WIDTH-1:0] r_rdata;
  logic                      r_err;

  logic                      w_found;
  logic [IDX_W-1:0]          w_winner;
  logic [IDX_W:0]            w_scan;
  logic [IDX_W-1:0]          w_ptr_nxt;
  logic                      w_grant;
  logic [NB_REQ-1:0]         w_gnt;
  logic                      w_complete;
  logic                      w_expire;

  // Round-robin search: first pending request at or above rr_ptr, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = {IDX_W{1'b0}};
    w_scan   = {(IDX_W+1){1'b0}};
    for (int i = 0; i < NB_REQ; i++) begin
      w_scan = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
      if (w_scan >= (IDX_W+1)'(NB_REQ)) begin
        w_scan = w_scan - (IDX_W+1)'(NB_REQ);
      end else begin
        w_scan = w_scan;
      end
      if (!w_found && req_i[w_scan[IDX_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_scan[IDX_W-1:0];
      end else begin
        w_found  = w_found;
      end
    end
    if (w_winner == IDX_W'(NB_REQ - 1)) begin
      w_ptr_nxt = {IDX_W{1'b0}};
    end else begin
      w_ptr_nxt = w_winner + IDX_W'(1);
    end
  end

  // Next-state logic, grant pulse and completion/expiry decode.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = {NB_REQ{1'b0}};
    w_grant     = 1'b0;
    w_complete  = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_gnt       = ONE_HOT0 << w_winner;
          w_state_nxt = ST_SETUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready in the expiry cycle still counts as a normal completion.
        if (pready_i) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (WD_EN && (r_wdog == WD_LAST)) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // On a grant: capture the winner's transfer and advance the round-robin pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= {IDX_W{1'b0}};
      r_owner  <= {IDX_W{1'b0}};
      r_pwrite <= 1'b0;
      r_paddr  <= {APB_ADDR_WIDTH{1'b0}};
      r_pwdata <= {APB_DATA_WIDTH{1'b0}};
    end else if (w_grant) begin
      r_rr_ptr <= w_ptr_nxt;
      r_owner  <= w_winner;
      r_pwrite <= we_i[w_winner];
      r_paddr  <= addr_i[w_winner];
      r_pwdata <= wdata_i[w_winner];
    end
  end

  // Watchdog: cleared while in SETUP, counts ACCESS cycles without pready.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wdog <= {WD_W{1'b0}};
    end else if (r_state == ST_SETUP) begin
      r_wdog <= {WD_W{1'b0}};
    end else if ((r_state == ST_ACCESS) && !pready_i) begin
      r_wdog <= r_wdog + WD_W'(1);
    end
  end

  // Completion registers: one-cycle rvalid pulse, data/error held until next completion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= {NB_REQ{1'b0}};
      r_rdata  <= {APB_DATA_WIDTH{1'b0}};
      r_err    <= 1'b0;
    end else if (w_complete) begin
      r_rvalid <= ONE_HOT0 << r_owner;
      r_rdata  <= r_pwrite ? {APB_DATA_WIDTH{1'b0}} : prdata_i;
      r_err    <= pslverr_i;
    end else if (w_expire) begin
      r_rvalid <= ONE_HOT0 << r_owner;
      r_rdata  <= {APB_DATA_WIDTH{1'b0}};
      r_err    <= 1'b1;
    end else begin
      r_rvalid <= {NB_REQ{1'b0}};
    end
  end

  // psel/penable decode straight from the state register so reset drops them at once.
  assign psel_o    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign penable_o = (r_state == ST_ACCESS);
  assign pwrite_o  = r_pwrite;
  assign paddr_o   = r_paddr;
  assign pwdata_o  = r_pwdata;
  assign gnt_o     = w_gnt;
  assign rvalid_o  = r_rvalid;
  assign rdata_o   = r_rdata;
  assign err_o     = r_err;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Testbench for apb_master_arbiter: directed vector table, hand-written
// round-robin / timeout / reset sequences, then randomized traffic checked
// against a transaction-level reference model.
module tb_apb_master_arbiter;
  localparam int NB = 3;
  localparam int TO = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NB-1:0]       req, we, req_b;
  logic [NB-1:0][31:0] addr, wdata;
  logic [31:0]         prdata;
  logic                pready, pslverr, pready_b;

  logic [NB-1:0] gnt, rvalid, gnt_b, rvalid_b;
  logic [31:0]   rdata, pwdata, paddr, rdata_b, pwdata_b, paddr_b;
  logic          err, psel, penable, pwrite, err_b, psel_b, penable_b, pwrite_b;

  int n_cmp = 0;
  int n_bad = 0;

  apb_master_arbiter #(.NB_REQ(NB), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr), .pwdata_o(pwdata),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr));

  apb_master_arbiter #(.NB_REQ(NB), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b),
    .psel_o(psel_b), .penable_o(penable_b), .pwrite_o(pwrite_b), .paddr_o(paddr_b), .pwdata_o(pwdata_b),
    .prdata_i(prdata), .pready_i(pready_b), .pslverr_i(pslverr));

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    int          waits;
    logic [31:0] rd;
    bit          slverr;
    logic [2:0]  exp_rv;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] oh(input int i);
    logic [NB-1:0] one;
    one = NB'(1);
    return one << i;
  endfunction

  // One complete transfer from an idle bus; starts and ends just after a negedge.
  task automatic do_xfer(input vec_t v);
    req[v.idx] = 1'b1; we[v.idx] = v.wr; addr[v.idx] = v.a; wdata[v.idx] = v.wd;
    pready = 1'b0; pslverr = 1'b0;
    #1;
    check("vec_gnt", gnt, oh(v.idx));
    check("vec_idle_psel", psel, 0);
    @(negedge clk); req[v.idx] = 1'b0; #1;
    check("vec_setup_ctl", {psel, penable}, 2'b10);
    check("vec_setup_addr", paddr, v.a);
    check("vec_setup_wr", pwrite, v.wr);
    check("vec_setup_wdata", pwdata, v.wd);
    for (int k = 0; k <= v.waits; k++) begin
      @(negedge clk);
      pready = (k == v.waits); prdata = v.rd; pslverr = v.slverr;
      #1;
      check("vec_access_ctl", {psel, penable}, 2'b11);
      check("vec_access_addr", paddr, v.a);
      check("vec_access_wr", pwrite, v.wr);
      check("vec_access_wdata", pwdata, v.wd);
      check("vec_access_rvalid", rvalid, 0);
    end
    @(negedge clk); pready = 1'b0; pslverr = 1'b0; #1;
    check("vec_rvalid", rvalid, v.exp_rv);
    check("vec_rdata", rdata, v.exp_rdata);
    check("vec_err", err, v.exp_err);
    check("vec_done_psel", psel, 0);
  endtask

  initial begin
    logic [2:0] eg[13];
    logic [2:0] er[13];
    logic [NB-1:0] gseen, rvseen, outst, exp_g, rv_now, rv_next;
    logic [31:0] rd_hold, rd_next, m_addr, m_wdata;
    bit err_hold, err_next, busy, m_we;
    int rr, ph, own, acc, j;

    vecs[0] = '{0, 1'b0, 32'h1A10_0004, 32'h0000_0000, 0, 32'hDEAD_BEEF, 1'b0, 3'b001, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{2, 1'b1, 32'h1A10_0010, 32'h0000_00A5, 4, 32'h1234_5678, 1'b0, 3'b100, 32'h0000_0000, 1'b0};
    vecs[2] = '{1, 1'b0, 32'h1A10_0020, 32'h0000_0000, 1, 32'hCAFE_0001, 1'b1, 3'b010, 32'hCAFE_0001, 1'b1};
    vecs[3] = '{1, 1'b0, 32'h1A10_0024, 32'h0000_0000, 0, 32'h0000_0042, 1'b0, 3'b010, 32'h0000_0042, 1'b0};
    vecs[4] = '{0, 1'b1, 32'h1A10_0030, 32'h8765_4321, 2, 32'hFFFF_0000, 1'b1, 3'b001, 32'h0000_0000, 1'b1};
    vecs[5] = '{2, 1'b0, 32'h1A10_0040, 32'h0000_0000, 7, 32'h5555_AAAA, 1'b0, 3'b100, 32'h5555_AAAA, 1'b0};

    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; prdata = '0;
    pready = 1'b0; pslverr = 1'b0; req_b = '0; pready_b = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", gnt, 0); check("rst_rvalid", rvalid, 0); check("rst_rdata", rdata, 0);
    check("rst_err", err, 0); check("rst_psel", psel, 0); check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0); check("rst_paddr", paddr, 0); check("rst_pwdata", pwdata, 0);
    @(negedge clk); rst = 1'b0;

    // Directed vector table, back to back (each grant lands in the prior rvalid cycle).
    for (int i = 0; i < 6; i++) do_xfer(vecs[i]);
    @(negedge clk); #1;
    check("hold_rvalid", rvalid, 0);
    check("hold_rdata", rdata, 32'h5555_AAAA);
    check("hold_err", err, 0);

    // Round robin with all three requesters high; pointer is 0 after reset-era grants 0,2,1,1,0,2.
    eg = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    er = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b001};
    @(negedge clk);
    we = '0; pready = 1'b1; prdata = 32'h0BAD_F00D; req = 3'b111;
    gseen = '0; rvseen = '0;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) begin
        @(negedge clk);
        req = req & ~gseen;
        if (rvseen[0] && c < 8) req[0] = 1'b1;
      end
      #1;
      check("rr_gnt", gnt, eg[c]);
      check("rr_rvalid", rvalid, er[c]);
      gseen = gnt; rvseen = rvalid;
    end
    pready = 1'b0;

    // Watchdog expiry with TIMEOUT=8: ACCESS exactly 8 cycles (2..9), rvalid+err at 10.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h1A10_0100; prdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) req[1] = 1'b0;
      #1;
      check("to_psel", psel, (c >= 1 && c <= 9));
      check("to_penable", penable, (c >= 2 && c <= 9));
      check("to_rvalid", rvalid, (c == 10) ? 3'b010 : 3'b000);
      if (c == 10) begin
        check("to_err", err, 1);
        check("to_rdata", rdata, 0);
      end
    end

    // TIMEOUT=0 instance: bus waits indefinitely until pready.
    @(negedge clk);
    req_b = 3'b001; we[0] = 1'b0; addr[0] = 32'h1A10_0200; wdata[0] = 32'h2468_ACE0;
    prdata = 32'h1357_9BDF; pready_b = 1'b0;
    #1; check("nto_gnt", gnt_b, 3'b001);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk); req_b = '0; #1;
      check("nto_ctl", {psel_b, penable_b, rvalid_b}, (c == 1) ? 5'b10000 : 5'b11000);
    end
    @(negedge clk); pready_b = 1'b1; #1;
    @(negedge clk); pready_b = 1'b0; #1;
    check("nto_rvalid", rvalid_b, 3'b001);
    check("nto_rdata", rdata_b, 32'h1357_9BDF);
    check("nto_err", err_b, 0);
    check("nto_paddr", paddr_b, 32'h1A10_0200);
    check("nto_pwrite", pwrite_b, 0);
    check("nto_pwdata", pwdata_b, 32'h2468_ACE0);

    // Reset during ACCESS: pointer is 2 before reset, so a post-reset 111 must grant 0.
    @(negedge clk);
    req[1] = 1'b1; addr[1] = 32'h1A10_0300; pready = 1'b0;
    #1; check("rm_gnt", gnt, 3'b010);
    @(negedge clk); req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("rm_penable_before", penable, 1);
    rst = 1'b1; #1;
    check("rm_psel_async", psel, 0);
    check("rm_penable_async", penable, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("rm_rvalid0", rvalid, 0); check("rm_rdata", rdata, 0); check("rm_err", err, 0);
    @(negedge clk); #1;
    check("rm_rvalid1", rvalid, 0);
    req = 3'b111; #1;
    check("rm_gnt_after", gnt, 3'b001);
    @(negedge clk); req = 3'b000; pready = 1'b1; prdata = 32'h0000_7777;
    @(negedge clk);
    @(negedge clk); #1;
    check("rm_rvalid_after", rvalid, 3'b001);
    check("rm_rdata_after", rdata, 32'h0000_7777);
    pready = 1'b0;

    // Randomized traffic against a transaction-level model.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req = '0; gseen = '0; rvseen = '0; outst = '0; rv_next = '0;
    rd_hold = '0; err_hold = 1'b0; rd_next = '0; err_next = 1'b0;
    busy = 1'b0; rr = 0; ph = 0; own = 0; acc = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      req   = req & ~gseen;
      outst = (outst | gseen) & ~rvseen;
      for (int i = 0; i < NB; i++) begin
        if (!req[i] && !outst[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1; we[i] = 1'($urandom); addr[i] = $urandom; wdata[i] = $urandom;
        end
      end
      pready = ($urandom_range(0, 2) == 0); pslverr = 1'($urandom); prdata = $urandom;
      #1;
      rv_now = rv_next; rv_next = '0;
      if (rv_now != 0) begin rd_hold = rd_next; err_hold = err_next; end
      check("rnd_rvalid", rvalid, rv_now);
      check("rnd_rdata", rdata, rd_hold);
      check("rnd_err", err, err_hold);
      exp_g = '0;
      if (!busy) begin
        check("rnd_idle_ctl", {psel, penable}, 2'b00);
        for (int k = 0; k < NB; k++) begin
          j = (rr + k) % NB;
          if (exp_g == 0 && req[j]) begin exp_g = oh(j); own = j; end
        end
        if (exp_g != 0) begin
          busy = 1'b1; ph = 1; rr = (own + 1) % NB;
          m_we = we[own]; m_addr = addr[own]; m_wdata = wdata[own];
        end
      end else begin
        check("rnd_ctl", {psel, penable}, (ph == 1) ? 2'b10 : 2'b11);
        check("rnd_paddr", paddr, m_addr);
        check("rnd_pwrite", pwrite, m_we);
        check("rnd_pwdata", pwdata, m_wdata);
        if (ph == 1) begin
          ph = 2; acc = 0;
        end else begin
          acc++;
          if (pready) begin
            rv_next = oh(own); rd_next = m_we ? 32'h0 : prdata; err_next = pslverr; busy = 1'b0;
          end else if (acc == TO) begin
            rv_next = oh(own); rd_next = 32'h0; err_next = 1'b1; busy = 1'b0;
          end
        end
      end
      check("rnd_gnt", gnt, exp_g);
      gseen = gnt; rvseen = rvalid;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #1000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "simulation time bound exceeded");
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares the single APB slave port of the peripheral APB node between `NB_REQ` on-chip requesters (core data port, debug unit, DMA). Each requester issues one transfer at a time over a simple req/gnt/rvalid handshake; the block picks a winner round-robin, runs the APB SETUP/ACCESS sequence toward the node, and returns read data and error status to the owner. A programmable watchdog terminates transfers that never see `pready` and reports them as errors.

## Interface
- `NB_REQ`, default 3: number of requesters, 2..8.
- `APB_ADDR_WIDTH`, default 32: address width.
- `APB_DATA_WIDTH`, default 32: data width.
- `TIMEOUT`, default 256: max ACCESS cycles before forced termination; 0 disables the watchdog.

Ports:
- `clk_i`  in  1: clock; all logic on the rising edge.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `req_i`  in  NB_REQ: per-requester transfer request; held until granted.
- `we_i`  in  NB_REQ: 1 = write, 0 = read; valid with `req_i`.
- `addr_i`  in  NB_REQ x APB_ADDR_WIDTH: transfer address.
- `wdata_i`  in  NB_REQ x APB_DATA_WIDTH: write data.
- `gnt_o`  out  NB_REQ: one-hot acceptance pulse, combinational in IDLE.
- `rvalid_o`  out  NB_REQ: one-hot completion pulse to the owner.
- `rdata_o`  out  APB_DATA_WIDTH: read data, valid with `rvalid_o`; shared by all requesters.
- `err_o`  out  1: completion error (pslverr or timeout), valid with `rvalid_o`.
- `psel_o`, `penable_o`, `pwrite_o`  out  1: APB control toward the node.
- `paddr_o`  out  APB_ADDR_WIDTH; `pwdata_o`  out  APB_DATA_WIDTH: APB address/write data.
- `prdata_i`  in  APB_DATA_WIDTH; `pready_i`  in  1; `pslverr_i`  in  1: APB response from the node.

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state IDLE.
- IDLE: if `req_i != 0`, winner = first set bit scanning from `rr_ptr` upward, wrapping modulo NB_REQ. `gnt_o[winner]=1` that cycle; latch winner index, `we`, `addr`, `wdata`; next state SETUP. No request: stay IDLE, `gnt_o=0`.
- `rr_ptr` <= (winner+1) mod NB_REQ on each grant; reset value 0 (requester 0 wins first tie).
- SETUP: `psel_o=1`, `penable_o=0`, paddr/pwrite/pwdata from latched values; always -> ACCESS.
- ACCESS: `psel_o=1`, `penable_o=1`. On `pready_i=1`: register `prdata_i` (reads; 0 for writes) into `rdata_o`, `pslverr_i` into `err_o`, set `rvalid_o[owner]` for the next cycle; -> IDLE.
- Watchdog: counter cleared entering ACCESS, +1 each ACCESS cycle without `pready_i`. If TIMEOUT!=0 and counter == TIMEOUT-1 with `pready_i=0`: -> IDLE, `rvalid_o[owner]=1`, `err_o=1`, `rdata_o=0` next cycle. `pready_i` in the same cycle as expiry wins (normal completion).
- `req_i` changes outside IDLE are ignored; a requester must keep `req_i` high until `gnt_o` and must not issue a new request before its `rvalid_o`.
- Address/control toward the node stay stable from SETUP through the end of ACCESS (APB rule).
- Outside SETUP/ACCESS: `psel_o=0`, `penable_o=0`; `paddr_o`/`pwdata_o`/`pwrite_o` hold last latched value.

## Timing
- Reset values: state IDLE, `rr_ptr=0`, `gnt_o=0`, `rvalid_o=0`, `rdata_o=0`, `err_o=0`, `psel_o=0`, `penable_o=0`, `pwrite_o=0`, `paddr_o=0`, `pwdata_o=0`, watchdog 0.
- Cycle N: IDLE, `gnt_o` pulse. N+1: SETUP. N+2: ACCESS. Zero-wait slave: `rvalid_o` at N+3; each wait state adds one cycle.
- `rvalid_o` cycle is IDLE: next grant can coincide with it; peak throughput one transfer per 3 cycles.
- `rvalid_o`, `rdata_o`, `err_o` registered; `rdata_o`/`err_o` hold until the next completion.
- Reset asserted mid-transfer: immediate return to reset values; `psel_o`/`penable_o` drop asynchronously; no `rvalid_o` issued for the aborted transfer.
- Timeout with TIMEOUT=T: ACCESS lasts exactly T cycles; `rvalid_o`+`err_o` the cycle after.

## Test plan
- Single read, req 0 addr 0x1A10_0004, zero-wait slave returns 0xDEAD_BEEF -> gnt cycle 0, psel cycle 1, penable cycle 2, `rvalid_o=3'b001`, `rdata_o=0xDEAD_BEEF`, `err_o=0` cycle 3.
- All three requesters held high after reset -> grant order 0,1,2,0; each `rvalid_o` one-hot to correct owner; grant coincides with prior `rvalid_o`.
- Write with 4 wait states, pwdata 0x0000_00A5 -> ACCESS 5 cycles, pwrite/paddr/pwdata stable throughout, `rvalid_o` cycle 7, `rdata_o=0`.
- Slave asserts `pslverr_i` with `pready_i` -> `err_o=1` with `rvalid_o`; next transfer proceeds normally, `err_o=0`.
- TIMEOUT=8, slave never ready -> ACCESS exactly 8 cycles, then psel drops, `rvalid_o` + `err_o=1`, `rdata_o=0`; TIMEOUT=0 -> bus waits indefinitely.
- `rst_i` pulsed during ACCESS -> psel/penable 0 immediately, no `rvalid_o`, next grant goes to requester 0.
